spi_instr_decoder: RTL and testbench

- Sits between the SPI byte bridge (sclk/mosi/miso serialiser) and the PWM register file inside top.
- Consumes received SPI bytes and turns each two-byte frame into a register access:
  - byte 0 is the command {rw, hi_lo, addr[5:0]};
  - byte 1 is write data, or a dummy byte during which read data is shifted out.
- Drives one-cycle read/write strobes toward the register file, and returns the read byte to the bridge for transmission on miso.

---
 rtl/pwm_pkg.sv | 27 ++
 rtl/spi_instr_decoder_if.sv | 25 ++
 rtl/spi_instr_decoder.sv | 93 +++++++++
 tb/tb_spi_instr_decoder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM block: register map, SPI command layout, decoder states.
package pwm_pkg;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 8;

  localparam logic [ADDR_W-1:0] PERIOD        = 6'h00;
  localparam logic [ADDR_W-1:0] COUNTER_EN    = 6'h02;
  localparam logic [ADDR_W-1:0] COMPARE1      = 6'h03;
  localparam logic [ADDR_W-1:0] COMPARE2      = 6'h05;
  localparam logic [ADDR_W-1:0] COUNTER_RESET = 6'h07;
  localparam logic [ADDR_W-1:0] COUNTER_VAL   = 6'h08;
  localparam logic [ADDR_W-1:0] PRESCALE      = 6'h0A;
  localparam logic [ADDR_W-1:0] UPNOTDOWN     = 6'h0B;
  localparam logic [ADDR_W-1:0] PWM_EN        = 6'h0C;
  localparam logic [ADDR_W-1:0] FUNCTIONS     = 6'h0D;

  localparam int unsigned CMD_RW = 7;
  localparam int unsigned CMD_HL = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/spi_instr_decoder_if.sv
// Byte-level link between the SPI bridge / register file and the instruction decoder.
interface spi_instr_decoder_if;

  logic                          cs_n;
  logic                          byte_sync;
  logic [pwm_pkg::DATA_W-1:0]    data_in;
  logic [pwm_pkg::DATA_W-1:0]    data_read;
  logic [pwm_pkg::DATA_W-1:0]    data_out;
  logic [pwm_pkg::ADDR_W-1:0]    addr;
  logic                          hi_lo;
  logic                          write;
  logic [pwm_pkg::DATA_W-1:0]    data_write;
  logic                          read;

  modport slave (
    input  cs_n, byte_sync, data_in, data_read,
    output data_out, addr, hi_lo, write, data_write, read
  );

  modport master (
    output cs_n, byte_sync, data_in, data_read,
    input  data_out, addr, hi_lo, write, data_write, read
  );

endinterface

// File: rtl/spi_instr_decoder.sv
// Turns two-byte SPI frames {cmd, data} into one-cycle register read/write strobes.
module spi_instr_decoder
  import pwm_pkg::*;
(
  input logic                clk,
  input logic                rst_n,
  spi_instr_decoder_if.slave bus
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_DATA = DATA;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]        state_q, state_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              hi_lo_q, hi_lo_d;
  logic [DATA_W-1:0] data_write_q, data_write_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              write_q, write_d;
  logic              read_q, read_d;

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rw_q         <= 1'b0;
      addr_q       <= '0;
      hi_lo_q      <= 1'b0;
      data_write_q <= '0;
      data_out_q   <= '0;
      write_q      <= 1'b0;
      read_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rw_q         <= rw_d;
      addr_q       <= addr_d;
      hi_lo_q      <= hi_lo_d;
      data_write_q <= data_write_d;
      data_out_q   <= data_out_d;
      write_q      <= write_d;
      read_q       <= read_d;
    end
  end

  // Next-state and output decode; cs_n high always wins over byte_sync.
  always_comb begin
    state_d      = state_q;
    rw_d         = rw_q;
    addr_d       = addr_q;
    hi_lo_d      = hi_lo_q;
    data_write_d = data_write_q;
    write_d      = 1'b0;
    read_d       = 1'b0;
    // Register file answers combinationally during the read strobe cycle.
    data_out_d   = read_q ? bus.data_read : data_out_q;

    if (bus.cs_n) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.byte_sync) begin
            addr_d  = bus.data_in[ADDR_W-1:0];
            hi_lo_d = bus.data_in[CMD_HL];
            rw_d    = bus.data_in[CMD_RW];
            read_d  = ~bus.data_in[CMD_RW];
            state_d = ST_DATA;
          end
        end
        ST_DATA: begin
          if (bus.byte_sync) begin
            if (rw_q) begin
              data_write_d = bus.data_in;
              write_d      = 1'b1;
            end
            state_d = ST_DONE;
          end
        end
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign bus.addr       = addr_q;
  assign bus.hi_lo      = hi_lo_q;
  assign bus.data_write = data_write_q;
  assign bus.data_out   = data_out_q;
  assign bus.write      = write_q;
  assign bus.read       = read_q;

endmodule

// File: tb/tb_spi_instr_decoder.sv
// Directed bench for spi_instr_decoder: write/read frames, abort, extra bytes, collision, reset.
module tb_spi_instr_decoder;

  logic clk;
  logic rst_n;

  spi_instr_decoder_if bus ();

  spi_instr_decoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int wr_cnt   = 0;
  int rd_cnt   = 0;
  int both_cnt = 0;
  int wr_snap;
  int rd_snap;

  // Strobe monitor sampled on the inactive edge.
  always @(negedge clk) begin
    if (bus.write) wr_cnt++;
    if (bus.read) rd_cnt++;
    if (bus.write && bus.read) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents a byte for one cycle; returns 1ns after the edge that sampled it.
  task automatic send_byte(input logic [7:0] b);
    bus.byte_sync = 1'b1;
    bus.data_in   = b;
    step(1);
    bus.byte_sync = 1'b0;
  endtask

  task automatic end_frame();
    bus.cs_n = 1'b1;
    step(2);
  endtask

  task automatic snap();
    wr_snap = wr_cnt;
    rd_snap = rd_cnt;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.cs_n      = 1'b1;
    bus.byte_sync = 1'b0;
    bus.data_in   = 8'h00;
    bus.data_read = 8'h00;
    step(2);
    chk("rst_addr", 32'(bus.addr), 32'h0);
    chk("rst_hi_lo", 32'(bus.hi_lo), 32'h0);
    chk("rst_write", 32'(bus.write), 32'h0);
    chk("rst_read", 32'(bus.read), 32'h0);
    chk("rst_data_write", 32'(bus.data_write), 32'h0);
    chk("rst_data_out", 32'(bus.data_out), 32'h0);
    rst_n = 1'b1;
    step(2);

    // Write frame 0x80 / 0x07.
    snap();
    bus.cs_n = 1'b0;
    step(1);
    send_byte(8'h80);
    chk("wr_cmd_no_read", 32'(bus.read), 32'h0);
    chk("wr_addr", 32'(bus.addr), 32'h00);
    chk("wr_hi_lo", 32'(bus.hi_lo), 32'h0);
    step(2);
    send_byte(8'h07);
    chk("wr_strobe", 32'(bus.write), 32'h1);
    chk("wr_data", 32'(bus.data_write), 32'h07);
    step(1);
    chk("wr_strobe_1clk", 32'(bus.write), 32'h0);
    end_frame();
    chk("wr_count", 32'(wr_cnt - wr_snap), 32'd1);
    chk("wr_no_reads", 32'(rd_cnt - rd_snap), 32'd0);

    // Read frame 0x48 / 0x00 with register data 0x5A.
    snap();
    bus.data_read = 8'h5A;
    bus.cs_n = 1'b0;
    step(1);
    send_byte(8'h48);
    chk("rd_strobe_t1", 32'(bus.read), 32'h1);
    chk("rd_addr", 32'(bus.addr), 32'h08);
    chk("rd_hi_lo", 32'(bus.hi_lo), 32'h1);
    chk("rd_data_out_t1", 32'(bus.data_out), 32'h00);
    step(1);
    chk("rd_strobe_1clk", 32'(bus.read), 32'h0);
    chk("rd_data_out_t2", 32'(bus.data_out), 32'h5A);
    bus.data_read = 8'h11;
    step(2);
    send_byte(8'h00);
    chk("rd_no_write", 32'(bus.write), 32'h0);
    end_frame();
    chk("rd_data_out_hold", 32'(bus.data_out), 32'h5A);
    chk("rd_count", 32'(rd_cnt - rd_snap), 32'd1);
    chk("rd_no_writes", 32'(wr_cnt - wr_snap), 32'd0);

    // Abort after command 0x83, then frame 0x8C / 0x01.
    snap();
    bus.cs_n = 1'b0;
    step(1);
    send_byte(8'h83);
    end_frame();
    chk("abort_no_write", 32'(wr_cnt - wr_snap), 32'd0);
    bus.cs_n = 1'b0;
    step(1);
    send_byte(8'h8C);
    send_byte(8'h01);
    chk("abort_next_strobe", 32'(bus.write), 32'h1);
    chk("abort_next_addr", 32'(bus.addr), 32'h0C);
    chk("abort_next_data", 32'(bus.data_write), 32'h01);
    end_frame();
    chk("abort_write_count", 32'(wr_cnt - wr_snap), 32'd1);

    // Extra bytes: 0x8D, 0x02, 0xFF, 0xFF.
    snap();
    bus.cs_n = 1'b0;
    step(1);
    send_byte(8'h8D);
    send_byte(8'h02);
    chk("extra_strobe", 32'(bus.write), 32'h1);
    chk("extra_addr", 32'(bus.addr), 32'h0D);
    chk("extra_data", 32'(bus.data_write), 32'h02);
    send_byte(8'hFF);
    chk("extra_b3_no_write", 32'(bus.write), 32'h0);
    send_byte(8'hFF);
    chk("extra_b4_no_write", 32'(bus.write), 32'h0);
    chk("extra_data_hold", 32'(bus.data_write), 32'h02);
    chk("extra_addr_hold", 32'(bus.addr), 32'h0D);
    end_frame();
    chk("extra_write_count", 32'(wr_cnt - wr_snap), 32'd1);
    chk("extra_read_count", 32'(rd_cnt - rd_snap), 32'd0);

    // Collision on the command byte and on the data byte.
    snap();
    bus.cs_n = 1'b0;
    step(1);
    bus.cs_n = 1'b1;
    send_byte(8'h81);
    step(1);
    chk("coll_cmd_addr", 32'(bus.addr), 32'h0D);
    bus.cs_n = 1'b0;
    step(1);
    send_byte(8'h84);
    bus.cs_n = 1'b1;
    send_byte(8'h99);
    step(2);
    chk("coll_no_strobes", 32'(wr_cnt - wr_snap + rd_cnt - rd_snap), 32'd0);
    bus.cs_n = 1'b0;
    step(1);
    send_byte(8'h82);
    send_byte(8'h33);
    chk("coll_next_strobe", 32'(bus.write), 32'h1);
    chk("coll_next_addr", 32'(bus.addr), 32'h02);
    chk("coll_next_data", 32'(bus.data_write), 32'h33);
    end_frame();
    chk("coll_write_count", 32'(wr_cnt - wr_snap), 32'd1);

    // Reset mid-frame after command 0x85.
    bus.cs_n = 1'b0;
    step(1);
    send_byte(8'h85);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_addr", 32'(bus.addr), 32'h0);
    chk("mrst_data_out", 32'(bus.data_out), 32'h0);
    chk("mrst_data_write", 32'(bus.data_write), 32'h0);
    chk("mrst_write", 32'(bus.write), 32'h0);
    step(1);
    #2;
    rst_n = 1'b1;
    step(1);
    snap();
    send_byte(8'h06);
    step(1);
    chk("mrst_no_write_after", 32'(wr_cnt - wr_snap), 32'd0);
    end_frame();
    snap();
    bus.cs_n = 1'b0;
    step(1);
    send_byte(8'h85);
    send_byte(8'h06);
    chk("mrst_next_strobe", 32'(bus.write), 32'h1);
    chk("mrst_next_addr", 32'(bus.addr), 32'h05);
    chk("mrst_next_data", 32'(bus.data_write), 32'h06);
    end_frame();
    chk("mrst_write_count", 32'(wr_cnt - wr_snap), 32'd1);

    chk("never_both", 32'(both_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
